id_ex_pipe: RTL

- Decode-to-execute pipeline register. It sits directly downstream of the decode register file.
- Captures the two read operands, register selectors, immediate, PC and control bundle every cycle.
- Detects load-use hazards and inserts a one-cycle bubble while stalling decode.
- Keeps held operands coherent with write-back while execute is stalled. This is needed because the register file only bypasses on the read cycle.

---
 rtl/id_ex_pipe.sv | 137 +++++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register with load-use bubble insertion and write-back refresh of held operands.
// Optional build macro ID_EX_PERF_EN adds perf_bubbles / perf_hold event counters.
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              wb_write,
  input  logic [4:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_hold,
`endif
  output logic              hazard_stall
);

  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_mem_read;
  logic              r_reg_write;

  logic w_load_use;
  logic w_take_hold;
  logic w_take_bubble;

  // r0 is compared like any other register because the register file writes it.
  assign w_load_use = r_valid & r_mem_read & r_reg_write & id_valid &
                      ((r_rd == id_rs1) | (r_rd == id_rs2));

  assign w_take_hold   = ~flush & ex_stall;
  assign w_take_bubble = ~flush & ~ex_stall & w_load_use;
  assign hazard_stall  = w_take_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_ctrl      <= '0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (ex_stall) begin
      // Register file only bypasses on its read cycle, so held operands track write-back here.
      if (wb_write && (wb_sel == r_rs1)) r_rs1_data <= wb_data;
      if (wb_write && (wb_sel == r_rs2)) r_rs2_data <= wb_data;
    end else if (w_load_use) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
    end else begin
      r_valid     <= id_valid;
      r_pc        <= id_pc;
      r_imm       <= id_imm;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_ctrl      <= id_ctrl;
      r_mem_read  <= id_valid & id_mem_read;
      r_reg_write <= id_valid & id_reg_write;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_imm       = r_imm;
  assign ex_rs1       = r_rs1;
  assign ex_rs2       = r_rs2;
  assign ex_rd        = r_rd;
  assign ex_rs1_data  = r_rs1_data;
  assign ex_rs2_data  = r_rs2_data;
  assign ex_ctrl      = r_ctrl;
  assign ex_mem_read  = r_mem_read;
  assign ex_reg_write = r_reg_write;

`ifdef ID_EX_PERF_EN
  logic [31:0] r_perf_bubbles;
  logic [31:0] r_perf_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_bubbles <= '0;
      r_perf_hold    <= '0;
    end else begin
      if (w_take_bubble) r_perf_bubbles <= r_perf_bubbles + 32'd1;
      if (w_take_hold)   r_perf_hold    <= r_perf_hold + 32'd1;
    end
  end

  assign perf_bubbles = r_perf_bubbles;
  assign perf_hold    = r_perf_hold;
`endif

endmodule
